pipe_stage_buffer: RTL and testbench

- Parametrised inter-stage pipeline register for the 16-bit RISC datapath; generalises the fixed EXE/MEM latch.
- Carries ALU result, store data, destination register, control field and regwrite through STAGES register slots.
- Adds valid tracking, stall (hold), flush (bubble insertion), a forwarding lookup across all in-flight slots, and a saturating bubble counter.

---
 rtl/pipe_stage_buffer.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// Parametrised inter-stage pipeline register for the 16-bit RISC datapath.
// STAGES slots with valid tracking, stall/flush, forwarding lookup and a bubble counter.
module pipe_stage_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned STAGES = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_store,
    input  logic [REG_W-1:0]  in_dest,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_regwrite,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_W-1:0]  query_reg,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store,
    output logic [REG_W-1:0]  out_dest,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_regwrite,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_val,
    output logic [CNT_W-1:0]  bubble_count
);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pipe_stage_buffer: STAGES must be in 1..4");
    end

    logic              valid_q    [STAGES];
    logic              valid_d    [STAGES];
    logic [DATA_W-1:0] alu_q      [STAGES];
    logic [DATA_W-1:0] alu_d      [STAGES];
    logic [DATA_W-1:0] store_q    [STAGES];
    logic [DATA_W-1:0] store_d    [STAGES];
    logic [REG_W-1:0]  dest_q     [STAGES];
    logic [REG_W-1:0]  dest_d     [STAGES];
    logic [CTRL_W-1:0] ctrl_q     [STAGES];
    logic [CTRL_W-1:0] ctrl_d     [STAGES];
    logic              regwrite_q [STAGES];
    logic              regwrite_d [STAGES];
    logic [CNT_W-1:0]  bubble_q;
    logic [CNT_W-1:0]  bubble_d;

    // Flush beats stall; an invalid input enters slot 0 as an all-zero bubble.
    always_comb begin
        for (int unsigned i = 0; i < STAGES; i++) begin
            valid_d[i]    = valid_q[i];
            alu_d[i]      = alu_q[i];
            store_d[i]    = store_q[i];
            dest_d[i]     = dest_q[i];
            ctrl_d[i]     = ctrl_q[i];
            regwrite_d[i] = regwrite_q[i];
        end
        if (flush) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_d[i]    = 1'b0;
                alu_d[i]      = '0;
                store_d[i]    = '0;
                dest_d[i]     = '0;
                ctrl_d[i]     = '0;
                regwrite_d[i] = 1'b0;
            end
        end else if (!stall) begin
            valid_d[0]    = in_valid;
            alu_d[0]      = in_valid ? in_alu : '0;
            store_d[0]    = in_valid ? in_store : '0;
            dest_d[0]     = in_valid ? in_dest : '0;
            ctrl_d[0]     = in_valid ? in_ctrl : '0;
            regwrite_d[0] = in_valid & in_regwrite;
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_d[i]    = valid_q[i-1];
                alu_d[i]      = alu_q[i-1];
                store_d[i]    = store_q[i-1];
                dest_d[i]     = dest_q[i-1];
                ctrl_d[i]     = ctrl_q[i-1];
                regwrite_d[i] = regwrite_q[i-1];
            end
        end
    end

    always_comb begin
        bubble_d = bubble_q;
        if (!valid_q[STAGES-1] && bubble_q != '1) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_q[i]    <= 1'b0;
                alu_q[i]      <= '0;
                store_q[i]    <= '0;
                dest_q[i]     <= '0;
                ctrl_q[i]     <= '0;
                regwrite_q[i] <= 1'b0;
            end
            bubble_q <= '0;
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                valid_q[i]    <= valid_d[i];
                alu_q[i]      <= alu_d[i];
                store_q[i]    <= store_d[i];
                dest_q[i]     <= dest_d[i];
                ctrl_q[i]     <= ctrl_d[i];
                regwrite_q[i] <= regwrite_d[i];
            end
            bubble_q <= bubble_d;
        end
    end

    // Scan from youngest slot; first match wins. R0 never forwards.
    always_comb begin
        logic found;
        found   = 1'b0;
        fwd_hit = 1'b0;
        fwd_val = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            if (!found && query_reg != '0 && valid_q[i] && regwrite_q[i] &&
                dest_q[i] == query_reg) begin
                found   = 1'b1;
                fwd_hit = 1'b1;
                fwd_val = alu_q[i];
            end
        end
    end

    assign out_valid    = valid_q[STAGES-1];
    assign out_alu      = alu_q[STAGES-1];
    assign out_store    = store_q[STAGES-1];
    assign out_dest     = dest_q[STAGES-1];
    assign out_ctrl     = valid_q[STAGES-1] ? ctrl_q[STAGES-1] : '0;
    assign out_regwrite = valid_q[STAGES-1] & regwrite_q[STAGES-1];
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a 2-slot and a 3-slot (4-bit counter)
// instance share one stimulus stream.
module tb_pipe_stage_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid, in_regwrite, stall, flush;
    logic [15:0] in_alu, in_store;
    logic [2:0]  in_dest, query_reg;
    logic [3:0]  in_ctrl;

    logic        d2_valid, d2_regwrite, d2_hit;
    logic [15:0] d2_alu, d2_store, d2_fval, d2_bub;
    logic [2:0]  d2_dest;
    logic [3:0]  d2_ctrl;

    logic        d3_valid, d3_regwrite, d3_hit;
    logic [15:0] d3_alu, d3_store, d3_fval;
    logic [3:0]  d3_bub;
    logic [2:0]  d3_dest;
    logic [3:0]  d3_ctrl;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pipe_stage_buffer #(.STAGES(2)) u_d2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu(in_alu),
        .in_store(in_store), .in_dest(in_dest), .in_ctrl(in_ctrl),
        .in_regwrite(in_regwrite), .stall(stall), .flush(flush),
        .query_reg(query_reg), .out_valid(d2_valid), .out_alu(d2_alu),
        .out_store(d2_store), .out_dest(d2_dest), .out_ctrl(d2_ctrl),
        .out_regwrite(d2_regwrite), .fwd_hit(d2_hit), .fwd_val(d2_fval),
        .bubble_count(d2_bub)
    );

    pipe_stage_buffer #(.STAGES(3), .CNT_W(4)) u_d3 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu(in_alu),
        .in_store(in_store), .in_dest(in_dest), .in_ctrl(in_ctrl),
        .in_regwrite(in_regwrite), .stall(stall), .flush(flush),
        .query_reg(query_reg), .out_valid(d3_valid), .out_alu(d3_alu),
        .out_store(d3_store), .out_dest(d3_dest), .out_ctrl(d3_ctrl),
        .out_regwrite(d3_regwrite), .fwd_hit(d3_hit), .fwd_val(d3_fval),
        .bubble_count(d3_bub)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] alu, input logic [2:0] dest,
                         input logic rw, input logic [3:0] ctrl, input logic [15:0] store);
        in_valid    = v;
        in_alu      = alu;
        in_dest     = dest;
        in_regwrite = rw;
        in_ctrl     = ctrl;
        in_store    = store;
    endtask

    initial begin
        drive(1'b0, 16'h0, 3'd0, 1'b0, 4'h0, 16'h0);
        stall = 1'b0;
        flush = 1'b0;
        query_reg = 3'd0;

        // Reset state
        step();
        step();
        check("rst_d2_valid", d2_valid, 0);
        check("rst_d2_alu", d2_alu, 0);
        check("rst_d2_bub", d2_bub, 0);
        check("rst_d3_bub", d3_bub, 0);
        check("rst_d2_hit", d2_hit, 0);
        reset = 1'b0;

        // Reset mid-stream (2 slots)
        drive(1'b1, 16'h1234, 3'd3, 1'b1, 4'hA, 16'h5555);
        query_reg = 3'd3;
        step();
        check("mid_slot0_hit", d2_hit, 1);
        check("mid_slot0_fval", d2_fval, 16'h1234);
        check("mid_e1_valid", d2_valid, 0);
        check("mid_e1_bub", d2_bub, 1);
        step();
        check("mid_e2_valid", d2_valid, 1);
        check("mid_e2_alu", d2_alu, 16'h1234);
        check("mid_e2_store", d2_store, 16'h5555);
        check("mid_e2_dest", d2_dest, 3);
        check("mid_e2_ctrl", d2_ctrl, 4'hA);
        check("mid_e2_rw", d2_regwrite, 1);
        check("mid_e2_bub", d2_bub, 2);
        #2 reset = 1'b1;
        #1;
        check("async_valid", d2_valid, 0);
        check("async_alu", d2_alu, 0);
        check("async_ctrl", d2_ctrl, 0);
        check("async_hit", d2_hit, 0);
        check("async_bub", d2_bub, 0);
        drive(1'b0, 16'h0, 3'd0, 1'b0, 4'h0, 16'h0);
        query_reg = 3'd0;
        step();
        reset = 1'b0;
        step();
        check("post_rst_bub_d2", d2_bub, 1);
        check("post_rst_bub_d3", d3_bub, 1);

        // Latency and order (3 slots)
        drive(1'b1, 16'h0001, 3'd1, 1'b1, 4'h1, 16'h0101);
        step();
        check("lat_e1_valid", d3_valid, 0);
        drive(1'b1, 16'h0002, 3'd2, 1'b1, 4'h1, 16'h0202);
        step();
        check("lat_e2_valid", d3_valid, 0);
        drive(1'b1, 16'h0003, 3'd3, 1'b1, 4'h1, 16'h0303);
        step();
        check("lat_e3_valid", d3_valid, 1);
        check("lat_e3_alu", d3_alu, 16'h0001);
        check("lat_e3_dest", d3_dest, 1);
        drive(1'b0, 16'h0, 3'd0, 1'b0, 4'h0, 16'h0);
        step();
        check("lat_e4_valid", d3_valid, 1);
        check("lat_e4_alu", d3_alu, 16'h0002);
        step();
        check("lat_e5_valid", d3_valid, 1);
        check("lat_e5_alu", d3_alu, 16'h0003);
        check("lat_e5_store", d3_store, 16'h0303);
        step();
        check("lat_e6_valid", d3_valid, 0);
        check("lat_e6_rw", d3_regwrite, 0);
        check("lat_bub_d3", d3_bub, 4);

        // Stall hold (2 slots)
        drive(1'b1, 16'h00AA, 3'd4, 1'b1, 4'h2, 16'h0);
        step();
        drive(1'b1, 16'h00BB, 3'd6, 1'b1, 4'h3, 16'h0);
        step();
        check("stall_pre_alu", d2_alu, 16'h00AA);
        stall = 1'b1;
        drive(1'b1, 16'h00CC, 3'd7, 1'b1, 4'h5, 16'h0);
        query_reg = 3'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_alu", d2_alu, 16'h00AA);
            check("stall_dest", d2_dest, 4);
            check("stall_hit", d2_hit, 1);
            check("stall_fval", d2_fval, 16'h00BB);
        end
        stall = 1'b0;
        drive(1'b0, 16'hDEAD, 3'd7, 1'b1, 4'hF, 16'hBEEF);
        step();
        check("unstall_alu", d2_alu, 16'h00BB);
        check("unstall_dest", d2_dest, 6);
        check("unstall_ctrl", d2_ctrl, 3);
        check("unstall_d3_alu", d3_alu, 16'h00AA);
        query_reg = 3'd7;
        #1;
        check("bubble_no_hit", d2_hit, 0);

        // Flush beats stall
        query_reg = 3'd6;
        #1;
        check("preflush_d3_hit", d3_hit, 1);
        check("preflush_d3_fval", d3_fval, 16'h00BB);
        drive(1'b1, 16'h00DD, 3'd5, 1'b1, 4'h6, 16'h0);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check("flush_d2_valid", d2_valid, 0);
        check("flush_d2_alu", d2_alu, 0);
        check("flush_d3_valid", d3_valid, 0);
        check("flush_d3_rw", d3_regwrite, 0);
        check("flush_d3_ctrl", d3_ctrl, 0);
        check("flush_d3_alu", d3_alu, 0);
        for (int q = 1; q < 8; q++) begin
            query_reg = 3'(q);
            #1;
            check("flush_d2_hit", d2_hit, 0);
            check("flush_d3_hit", d3_hit, 0);
        end
        stall = 1'b0;
        flush = 1'b0;

        // Forwarding priority (3 slots)
        drive(1'b1, 16'h0077, 3'd5, 1'b1, 4'h1, 16'h0);
        step();
        drive(1'b1, 16'h0022, 3'd2, 1'b0, 4'h1, 16'h0);
        step();
        drive(1'b1, 16'h0055, 3'd5, 1'b1, 4'h1, 16'h0);
        step();
        query_reg = 3'd5;
        #1;
        check("fwd_young_hit", d3_hit, 1);
        check("fwd_young_val", d3_fval, 16'h0055);
        check("fwd_out_alu", d3_alu, 16'h0077);
        query_reg = 3'd2;
        #1;
        check("fwd_norw_hit", d3_hit, 0);
        check("fwd_norw_val", d3_fval, 0);
        drive(1'b1, 16'h0099, 3'd0, 1'b1, 4'h1, 16'h0);
        step();
        query_reg = 3'd0;
        #1;
        check("fwd_r0_hit", d3_hit, 0);
        check("fwd_r0_val", d3_fval, 0);
        query_reg = 3'd5;
        #1;
        check("fwd_s1_hit", d3_hit, 1);
        check("fwd_s1_val", d3_fval, 16'h0055);
        check("gate_valid", d3_valid, 1);
        check("gate_rw", d3_regwrite, 0);
        check("gate_alu", d3_alu, 16'h0022);
        check("mid_bub_d3", d3_bub, 13);

        // Counter saturation
        drive(1'b0, 16'h0, 3'd0, 1'b0, 4'h0, 16'h0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("sat_d3_bub", d3_bub, (k < 15) ? k : 15);
            check("sat_d2_bub", d2_bub, k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
